obv_stat_snapshot: RTL

//  Single-clock statistics accumulator that produces windowed snapshots for the multi-bit CDC stage directly downstream.
//  It counts events and their byte totals every cycle, without loss. Every PERIOD cycles, or on flush, it latches the

---
 rtl/obv_stat_pkg.sv | 18 +
 rtl/obv_stat_snapshot_if.sv | 25 ++
 rtl/obv_sat_acc.sv | 32 +++
 rtl/obv_stat_snapshot.sv | 98 +++++++++
 4 files changed

// File: rtl/obv_stat_pkg.sv
// rtl/obv_stat_pkg.sv - snapshot word sizing and field positions
package obv_stat_pkg;

    localparam int unsigned BYTE_LSB = 0;

    function automatic int unsigned snap_w(input int unsigned cnt_w);
        return 2 * cnt_w + 1;
    endfunction

    function automatic int unsigned pkt_lsb(input int unsigned cnt_w);
        return cnt_w;
    endfunction

    function automatic int unsigned ovf_bit(input int unsigned cnt_w);
        return 2 * cnt_w;
    endfunction

endpackage

// File: rtl/obv_stat_snapshot_if.sv
// rtl/obv_stat_snapshot_if.sv - event input and snapshot valid/ready port bundle
interface obv_stat_snapshot_if #(
    parameter int CNT_W = 32,
    parameter int INC_W = 16
) ();
    import obv_stat_pkg::*;

    logic                        evt_vld;
    logic [INC_W-1:0]            evt_bytes;
    logic                        flush;
    logic [snap_w(CNT_W)-1:0]    snap_dout;
    logic                        snap_vld;
    logic                        snap_rdy;

    modport master (
        output evt_vld, evt_bytes, flush, snap_rdy,
        input  snap_dout, snap_vld
    );

    modport slave (
        input  evt_vld, evt_bytes, flush, snap_rdy,
        output snap_dout, snap_vld
    );

endinterface

// File: rtl/obv_sat_acc.sv
// rtl/obv_sat_acc.sv - saturating accumulator with load/add select and overflow flag
module obv_sat_acc #(
    parameter int W     = 32,
    parameter int INC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [INC_W-1:0] inc,
    output logic [W-1:0]     acc,
    output logic             ovf
);

    logic [W:0] sum;

    // One extra bit catches the carry out that signals saturation.
    assign sum = {1'b0, acc} + (W+1)'(inc);
    assign ovf = !load && sum[W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (load) begin
            acc <= W'(inc);
        end else if (sum[W]) begin
            acc <= '1;
        end else begin
            acc <= sum[W-1:0];
        end
    end

endmodule

// File: rtl/obv_stat_snapshot.sv
// rtl/obv_stat_snapshot.sv - windowed packet/byte statistics with held snapshot output
module obv_stat_snapshot
    import obv_stat_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int INC_W  = 16,
    parameter int PERIOD = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    obv_stat_snapshot_if.slave bus
);

    localparam int SW       = int'(snap_w(CNT_W));
    localparam int OVF_BIT  = int'(ovf_bit(CNT_W));
    localparam int PKT_LSB  = int'(pkt_lsb(CNT_W));
    localparam int BYTE_OFS = int'(BYTE_LSB);
    localparam int TW       = $clog2(PERIOD);

    logic [TW-1:0]    timer;
    logic             tick;
    logic             pending;
    logic             ovf_acc;
    logic             free;
    logic             take;
    logic [CNT_W-1:0] pkt_acc;
    logic [CNT_W-1:0] byte_acc;
    logic             pkt_ovf;
    logic             byte_ovf;
    logic [INC_W-1:0] byte_inc;
    logic [SW-1:0]    snap_word;
    logic [SW-1:0]    snap_dout_q;
    logic             snap_vld_q;

    assign tick     = (timer == TW'(PERIOD - 1));
    assign free     = !snap_vld_q || bus.snap_rdy;
    assign take     = (pending || tick || bus.flush) && free;
    assign byte_inc = bus.evt_vld ? bus.evt_bytes : '0;

    always_comb begin
        snap_word                      = '0;
        snap_word[OVF_BIT]             = ovf_acc;
        snap_word[PKT_LSB +: CNT_W]    = pkt_acc;
        snap_word[BYTE_OFS +: CNT_W]   = byte_acc;
    end

    // Events in the take cycle seed the new window through the load path.
    obv_sat_acc #(.W(CNT_W), .INC_W(1)) u_pkt_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (take),
        .inc   (bus.evt_vld),
        .acc   (pkt_acc),
        .ovf   (pkt_ovf)
    );

    obv_sat_acc #(.W(CNT_W), .INC_W(INC_W)) u_byte_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (take),
        .inc   (byte_inc),
        .acc   (byte_acc),
        .ovf   (byte_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer       <= '0;
            pending     <= 1'b0;
            ovf_acc     <= 1'b0;
            snap_dout_q <= '0;
            snap_vld_q  <= 1'b0;
        end else begin
            timer <= tick ? '0 : timer + 1'b1;
            if (take) begin
                snap_dout_q <= snap_word;
                snap_vld_q  <= 1'b1;
                pending     <= 1'b0;
                ovf_acc     <= 1'b0;
            end else begin
                // A window boundary seen while blocked merges into the pending one.
                if (tick || bus.flush) begin
                    pending <= 1'b1;
                end
                if (pkt_ovf || byte_ovf) begin
                    ovf_acc <= 1'b1;
                end
                if (bus.snap_rdy) begin
                    snap_vld_q <= 1'b0;
                end
            end
        end
    end

    assign bus.snap_dout = snap_dout_q;
    assign bus.snap_vld  = snap_vld_q;

endmodule
